aes_key_expand: RTL and testbench

Iterative on-the-fly AES-128 key schedule for the accelerator datapath. The block loads a 128-bit cipher key and produces one round key per step, tracking its own round index 0..10. It sits beside the round counter and feeds the AddRoundKey stage. The controller pulses `next_i` in lockstep with the counter enable, so `round_o` and the counter value stay equal.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_key_expand.sv | 111 +++++++++++
 tb/tb_aes_key_expand.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and word helpers for the key schedule
// and the round datapath.
package aes_pkg;

   localparam int AES_KEY_W      = 128;
   localparam int AES_WORD_W     = 32;
   localparam int AES_NUM_ROUNDS = 10;

   typedef logic [AES_WORD_W-1:0] aes_word_t;
   typedef logic [AES_KEY_W-1:0]  aes_key_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_READY = 1'b1
   } key_state_t;

   // Round constants indexed by the round being produced; entry 0 and the
   // tail past round 10 are never selected and pad the table to a power of two.
   localparam logic [7:0] RCON [0:15] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   // {b0,b1,b2,b3} -> {b1,b2,b3,b0}, b0 being the most significant byte.
   function automatic aes_word_t rot_word(input aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// One-byte forward AES S-box, purely combinational. Shared between the key
// schedule SubWord and the SubBytes stage.
module aes_sbox (
   input  logic [7:0] plain,
   output logic [7:0] subst
);

   // Row 0x00 sits in the most significant bits, so byte x lives at
   // bit offset 8*(255-x); ~plain is 255-plain for an 8-bit value.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign subst = SBOX_TBL[{~plain, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key and steps one round key
// per accepted next_i. Defining AES_KEY_INV_EN adds inverse stepping on
// prev_i, reusing the forward S-boxes through a mux on the SubWord input.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           load_i,
   input  logic [127:0]   key_i,
   input  logic           next_i,
   input  logic           prev_i,
   output logic [127:0]   round_key_o,
   output logic [3:0]     round_o,
   output logic           valid_o,
   output logic           last_o
);

   localparam logic [3:0] LAST_ROUND = 4'(AES_NUM_ROUNDS);

   key_state_t state_q;
   aes_key_t   key_q;
   logic [3:0] round_q;
   logic       last_q;

   aes_word_t  w0, w1, w2, w3;
   aes_word_t  sub_in, sub_out;
   aes_key_t   fwd_key;
   aes_word_t  fwd_t;
   logic [3:0] fwd_idx;
   logic       step_fwd;
   logic       step_inv;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // Clamp keeps the RCON index in range at round 10, where stepping is blocked anyway.
   assign fwd_idx = (round_q == LAST_ROUND) ? round_q : round_q + 4'd1;

   // SubWord: four forward S-boxes, one per byte.
   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .plain (sub_in[8*i +: 8]),
         .subst (sub_out[8*i +: 8])
      );
   end

`ifdef AES_KEY_INV_EN
   aes_word_t inv_w0, inv_w1, inv_w2, inv_w3;
   aes_key_t  inv_key;
   logic      inv_sel;

   assign inv_sel = prev_i && !next_i;
   assign inv_w3  = w3 ^ w2;
   assign inv_w2  = w2 ^ w1;
   assign inv_w1  = w1 ^ w0;
   // The inverse step needs SubWord of the recovered w3, so the shared
   // S-boxes see either w3 or w3^w2 depending on direction.
   assign sub_in  = inv_sel ? rot_word(inv_w3) : rot_word(w3);
   assign inv_w0  = w0 ^ sub_out ^ {RCON[round_q], 24'h0};
   assign inv_key = {inv_w0, inv_w1, inv_w2, inv_w3};
   assign step_inv = (state_q == ST_READY) && inv_sel && (round_q != 4'd0);
   assign step_fwd = (state_q == ST_READY) && next_i && !prev_i && (round_q != LAST_ROUND);
`else
   logic unused_prev;

   assign unused_prev = prev_i;
   assign sub_in      = rot_word(w3);
   assign step_inv    = 1'b0;
   assign step_fwd    = (state_q == ST_READY) && next_i && (round_q != LAST_ROUND);
`endif

   assign fwd_t   = sub_out ^ {RCON[fwd_idx], 24'h0};
   assign fwd_key[127:96] = w0 ^ fwd_t;
   assign fwd_key[95:64]  = w1 ^ fwd_key[127:96];
   assign fwd_key[63:32]  = w2 ^ fwd_key[95:64];
   assign fwd_key[31:0]   = w3 ^ fwd_key[63:32];

   // Load/step state machine; reset beats load, load beats any step.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         round_q <= 4'd0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         state_q <= ST_READY;
         key_q   <= key_i;
         round_q <= 4'd0;
         last_q  <= 1'b0;
      end else if (step_fwd) begin
         key_q   <= fwd_key;
         round_q <= round_q + 4'd1;
         last_q  <= (round_q == LAST_ROUND - 4'd1);
`ifdef AES_KEY_INV_EN
      end else if (step_inv) begin
         key_q   <= inv_key;
         round_q <= round_q - 4'd1;
         last_q  <= 1'b0;
`endif
      end
   end

   assign round_key_o = key_q;
   assign round_o     = round_q;
   assign valid_o     = (state_q == ST_READY);
   assign last_o      = last_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: a driver issues one operation per cycle
// and queues the expected outputs; a monitor pops and compares on the
// falling edge. Inverse-step vectors are compiled in with AES_KEY_INV_EN.
module tb_aes_key_expand;

   logic         clk_i = 1'b0;
   logic         reset_i, load_i, next_i, prev_i;
   logic [127:0] key_i;
   logic [127:0] round_key_o;
   logic [3:0]   round_o;
   logic         valid_o, last_o;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   round;
      logic         valid;
      logic         last;
      string        name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [127:0] rk [0:10];
   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;

   aes_key_expand dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (load_i),
      .key_i       (key_i),
      .next_i      (next_i),
      .prev_i      (prev_i),
      .round_key_o (round_key_o),
      .round_o     (round_o),
      .valid_o     (valid_o),
      .last_o      (last_o)
   );

   always #5 clk_i = ~clk_i;

   // Monitor: compare DUT outputs against the oldest queued expectation.
   always @(negedge clk_i) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks += 4;
         if (round_key_o !== e.key) begin
            errors++;
            $display("FAIL %s key got %h want %h", e.name, round_key_o, e.key);
         end
         if (round_o !== e.round) begin
            errors++;
            $display("FAIL %s round got %0d want %0d", e.name, round_o, e.round);
         end
         if (valid_o !== e.valid) begin
            errors++;
            $display("FAIL %s valid got %b want %b", e.name, valid_o, e.valid);
         end
         if (last_o !== e.last) begin
            errors++;
            $display("FAIL %s last got %b want %b", e.name, last_o, e.last);
         end
      end
   end

   // Drive one cycle of inputs, then queue what must be visible after that edge.
   task automatic step(input logic rst, input logic ld, input logic nx, input logic pv,
                       input logic [127:0] k, input logic [127:0] ek, input logic [3:0] er,
                       input logic ev, input string nm);
      exp_t e;
      @(negedge clk_i);
      #1;
      reset_i = rst; load_i = ld; next_i = nx; prev_i = pv; key_i = k;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0; load_i = 1'b0; next_i = 1'b0; prev_i = 1'b0;
      e.key = ek; e.round = er; e.valid = ev; e.last = (er == 4'd10); e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic load_a();
      step(0, 1, 0, 0, KEY_A, rk[0], 4'd0, 1'b1, "load");
   endtask

   task automatic fwd_to(input int from, input int to);
      for (int r = from + 1; r <= to; r++)
         step(0, 0, 1, 0, '0, rk[r], 4'(r), 1'b1, $sformatf("next_r%0d", r));
   endtask

   initial begin
      rk[0]  = KEY_A;
      rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset_i = 1'b1; load_i = 1'b0; next_i = 1'b0; prev_i = 1'b0; key_i = '0;
      step(1, 0, 0, 0, '0, '0, 4'd0, 1'b0, "reset");
      step(0, 0, 1, 0, '0, '0, 4'd0, 1'b0, "next_idle");

      load_a();
      fwd_to(0, 10);
      step(0, 0, 1, 0, '0, rk[10], 4'd10, 1'b1, "next_at_10");

`ifdef AES_KEY_INV_EN
      for (int r = 9; r >= 0; r--)
         step(0, 0, 0, 1, '0, rk[r], 4'(r), 1'b1, $sformatf("prev_r%0d", r));
      step(0, 0, 0, 1, '0, rk[0], 4'd0, 1'b1, "prev_at_0");
      fwd_to(0, 3);
      step(0, 0, 1, 1, '0, rk[3], 4'd3, 1'b1, "next_prev_both");
`endif

      // Load wins over next at round 5.
      load_a();
      fwd_to(0, 5);
      step(0, 1, 1, 0, '0, '0, 4'd0, 1'b1, "load_with_next");
      step(0, 0, 1, 0, '0, ZERO_R1, 4'd1, 1'b1, "zero_key_r1");

      // Reset mid-schedule, then a full rerun.
      load_a();
      fwd_to(0, 6);
      step(1, 0, 1, 0, KEY_A, '0, 4'd0, 1'b0, "reset_mid");
      step(0, 0, 1, 0, '0, '0, 4'd0, 1'b0, "next_after_reset");
      load_a();
      fwd_to(0, 10);
      step(0, 0, 0, 0, '0, rk[10], 4'd10, 1'b1, "hold");

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
